// File: rtl/game_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : game_rom_arbiter
//  Purpose  : Shares one single-port pixelmap ROM between NUM_REQ render
//             requesters (background scanout, sprite fetchers, HUD).
//             One access is granted per clock using a round-robin search.
//             The granted address is registered onto the ROM. Each read word
//             is returned to its issuer after a fixed latency, with a
//             one-hot strobe.
//  Ports    : iClock      - clock, rising edge
//             iReset      - synchronous active-high reset
//             iReq        - per-requester request level
//             iAddr       - packed addresses, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//             oGrant      - combinational one-hot accept (transfer this cycle)
//             oRomAddress - registered ROM address
//             iRomData    - ROM read data (ROM_LATENCY cycles after address)
//             oValid      - registered one-hot return strobe
//             oData       - registered return word (meaningful while oValid != 0)
//  Options  : `define ARB_PRIORITY0_EN gives requester 0 strict priority.
//             With that option, requesters 1..NUM_REQ-1 rotate among
//             themselves whenever requester 0 is idle.
//  Revision : 1.0 - initial release
// ============================================================================
module game_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 16,
    parameter int ROM_LATENCY = 2
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [NUM_REQ-1:0]            iReq,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] iAddr,
    output logic [NUM_REQ-1:0]            oGrant,
    output logic [ADDR_WIDTH-1:0]         oRomAddress,
    input  logic [DATA_WIDTH-1:0]         iRomData,
    output logic [NUM_REQ-1:0]            oValid,
    output logic [DATA_WIDTH-1:0]         oData
);

    localparam int c_ptr_w     = $clog2(NUM_REQ);
    // One stage for the address register plus ROM_LATENCY stages for the ROM.
    localparam int c_tag_depth = ROM_LATENCY + 1;
    localparam logic [c_ptr_w-1:0] c_rr_reset = c_ptr_w'(NUM_REQ - 1);

    logic [c_ptr_w-1:0]    r_rr_ptr;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [NUM_REQ-1:0]    r_tag [c_tag_depth];
    logic [NUM_REQ-1:0]    r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic [NUM_REQ-1:0]    w_grant;
    logic [c_ptr_w-1:0]    w_grant_idx;
    logic [c_ptr_w-1:0]    w_idx;
    logic                  w_found;
    logic                  w_ptr_update;
    logic [ADDR_WIDTH-1:0] w_grant_addr;

    // Round-robin search starting one past the last winner, wrapping modulo
    // NUM_REQ. The first requesting index found wins.
    always_comb begin
        w_grant      = '0;
        w_grant_idx  = r_rr_ptr;
        w_idx        = '0;
        w_found      = 1'b0;
        w_ptr_update = 1'b0;
`ifdef ARB_PRIORITY0_EN
        // The scanout requester always wins. It leaves the rotation pointer
        // alone so the other requesters resume where they left off.
        if (iReq[0]) begin
            w_grant[0]  = 1'b1;
            w_grant_idx = '0;
            w_found     = 1'b1;
        end
`endif
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = c_ptr_w'((int'(r_rr_ptr) + off) % NUM_REQ);
`ifdef ARB_PRIORITY0_EN
            if (!w_found && (w_idx != '0) && iReq[w_idx]) begin
`else
            if (!w_found && iReq[w_idx]) begin
`endif
                w_grant[w_idx] = 1'b1;
                w_grant_idx    = w_idx;
                w_found        = 1'b1;
                w_ptr_update   = 1'b1;
            end
        end
        // Nothing may be accepted while reset is held.
        if (iReset) begin
            w_grant      = '0;
            w_found      = 1'b0;
            w_ptr_update = 1'b0;
        end
    end

    assign w_grant_addr = iAddr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_rr_ptr   <= c_rr_reset;
            r_rom_addr <= '0;
            r_valid    <= '0;
            r_data     <= '0;
            for (int s = 0; s < c_tag_depth; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_ptr_update) begin
                r_rr_ptr <= w_grant_idx;
            end
            if (w_found) begin
                r_rom_addr <= w_grant_addr;
            end
            // The tag travels alongside the access. An empty slot carries 0.
            r_tag[0] <= w_grant;
            for (int s = 1; s < c_tag_depth; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            // The exiting tag lines up with the ROM word on iRomData.
            r_valid <= r_tag[c_tag_depth-1];
            if (|r_tag[c_tag_depth-1]) begin
                r_data <= iRomData;
            end
        end
    end

    assign oGrant      = w_grant;
    assign oRomAddress = r_rom_addr;
    assign oValid      = r_valid;
    assign oData       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_game_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_rom_arbiter
//  Purpose  : Self-checking bench for game_rom_arbiter. Directed scenarios
//             are followed by a randomized phase. Expected grants and returns
//             come from a behavioural reference model: the last winner index,
//             a modular search over the request vector, and a queue of
//             pending returns with due cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_rom_arbiter;

    localparam int N   = 4;
    localparam int AW  = 17;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic              iClock = 1'b0;
    logic              iReset;
    logic [N-1:0]      iReq;
    logic [N*AW-1:0]   iAddr;
    logic [N-1:0]      oGrant;
    logic [AW-1:0]     oRomAddress;
    logic [DW-1:0]     iRomData;
    logic [N-1:0]      oValid;
    logic [DW-1:0]     oData;

    game_rom_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_LATENCY(LAT)
    ) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iReq       (iReq),
        .iAddr      (iAddr),
        .oGrant     (oGrant),
        .oRomAddress(oRomAddress),
        .iRomData   (iRomData),
        .oValid     (oValid),
        .oData      (oData)
    );

    always #5 iClock = ~iClock;

    // ROM contents: one known word at 0x00123, otherwise an address hash.
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [31:0] t;
        t = {15'd0, a} * 32'd40503 + 32'h1234;
        return (a == 17'h00123) ? 16'hBEEF : t[15:0];
    endfunction

    // Registered-in, registered-out ROM with LAT cycles of latency.
    logic [DW-1:0] rom_q [LAT];
    always @(posedge iClock) begin
        rom_q[0] <= rom_fn(oRomAddress);
        for (int k = 1; k < LAT; k++) rom_q[k] <= rom_q[k-1];
    end
    assign iRomData = rom_q[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int           idx;
        logic [DW-1:0] data;
        int           due;
    } ret_t;

    ret_t          pend[$];
    int            cyc;
    int            last;
    logic [AW-1:0] exp_rom_addr;
    int            n_assert;
    int            n_fail;

    function automatic int model_grant(input logic [N-1:0] req);
`ifdef ARB_PRIORITY0_EN
        if (req[0]) return 0;
`endif
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (last + off) % N;
`ifdef ARB_PRIORITY0_EN
            if (idx == 0) continue;
`endif
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N*AW-1:0] pack4(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                              input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Checks the registered outputs visible in the current cycle.
    task automatic check_outputs();
        logic [N-1:0]  ev;
        logic [DW-1:0] ed;
        ev = '0;
        ed = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            ev = N'(1) << pend[0].idx;
            ed = pend[0].data;
            void'(pend.pop_front());
        end
        check("valid", 64'(oValid), 64'(ev));
        if (ev != '0) check("data", 64'(oData), 64'(ed));
        check("rom_addr", 64'(oRomAddress), 64'(exp_rom_addr));
    endtask

    // One functional cycle: drive, check, advance the model, clock.
    task automatic run_cycle(input logic [N-1:0] req, input logic [N*AW-1:0] addrs);
        int            g;
        logic [N-1:0]  eg;
        logic [AW-1:0] a;
        iReset = 1'b0;
        iReq   = req;
        iAddr  = addrs;
        #1;
        g  = model_grant(req);
        eg = (g >= 0) ? (N'(1) << g) : '0;
        check("grant", 64'(oGrant), 64'(eg));
        check_outputs();
        if (g >= 0) begin
            a = addrs[g*AW +: AW];
            pend.push_back('{g, rom_fn(a), cyc + LAT + 2});
            exp_rom_addr = a;
`ifdef ARB_PRIORITY0_EN
            if (g != 0) last = g;
`else
            last = g;
`endif
        end
        @(posedge iClock);
        #1;
        cyc++;
    endtask

    task automatic reset_cycle(input logic [N-1:0] req);
        iReset = 1'b1;
        iReq   = req;
        #1;
        check("grant_in_reset", 64'(oGrant), 64'd0);
        check_outputs();
        // Everything in flight is discarded by the reset edge.
        pend.delete();
        last         = N - 1;
        exp_rom_addr = '0;
        @(posedge iClock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle('0, '0);
    endtask

    initial begin
        logic [N*AW-1:0] ra;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        iReset   = 1'b1;
        iReq     = '0;
        iAddr    = '0;
        repeat (2) @(posedge iClock);
        #1;
        last         = N - 1;
        exp_rom_addr = '0;

        // Reset state, with requests present that must not be granted.
        reset_cycle(4'b1111);
        check("data_after_reset", 64'(oData), 64'd0);

        // Single read to a known address returns 0xBEEF four cycles later.
        run_cycle(4'b0001, pack4(17'h00123, 17'h0, 17'h0, 17'h0));
        idle(5);

        // All four requesting for eight cycles: 0,1,2,3,0,1,2,3.
        reset_cycle('0);
        for (int i = 0; i < 8; i++)
            run_cycle(4'b1111, pack4(AW'(100 + i), AW'(200 + i), AW'(300 + i), AW'(400 + i)));
        idle(5);

        // Requester 2 alone, back-to-back, addresses 10..15.
        for (int i = 0; i < 6; i++)
            run_cycle(4'b0100, pack4(17'h0, 17'h0, AW'(10 + i), 17'h0));
        idle(5);

        // Requesters 1 and 3. Requester 1 drops after its first grant.
        reset_cycle('0);
        run_cycle(4'b1010, pack4(17'h0, 17'h11, 17'h0, 17'h33));
        for (int i = 0; i < 3; i++)
            run_cycle(4'b1000, pack4(17'h0, 17'h0, 17'h0, AW'(17'h34 + i)));
        idle(5);

        // Reset with three reads in flight. No returns may appear afterwards.
        for (int i = 0; i < 3; i++)
            run_cycle(4'b1111, pack4(AW'(500 + i), AW'(600 + i), AW'(700 + i), AW'(800 + i)));
        reset_cycle('0);
        idle(4);
        run_cycle(4'b0011, pack4(17'h1A0, 17'h1A1, 17'h0, 17'h0));
        idle(5);

        // Priority scenario (round-robin results in the default build).
        reset_cycle('0);
        for (int i = 0; i < 3; i++)
            run_cycle(4'b0111, pack4(AW'(900 + i), AW'(910 + i), AW'(920 + i), 17'h0));
        for (int i = 0; i < 2; i++)
            run_cycle(4'b0110, pack4(17'h0, AW'(930 + i), AW'(940 + i), 17'h0));
        idle(5);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) ra[r*AW +: AW] = AW'($urandom);
            if ($urandom_range(0, 39) == 0) reset_cycle(N'($urandom));
            else run_cycle(N'($urandom), ra);
        end
        idle(6);
        check("all_returns_seen", 64'(pend.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_rom_arbiter.md
# game_rom_arbiter

Shares one single-port pixelmap ROM between several render requesters, such as background scanout, sprite fetchers and the HUD. It arbitrates one access per clock with a round-robin grant and drives the ROM address. It returns each read word to the requester that issued it, with fixed latency. It sits between the render controller's fetch units and the ROM instance.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 17: ROM address width.
- DATA_WIDTH, 16: ROM word width.
- ROM_LATENCY, 2: cycles from a change on oRomAddress to the corresponding valid word on iRomData (registered-in, registered-out ROM).

Ports:
- iClock, input, 1: the single clock; every register is clocked on its rising edge.
- iReset, input, 1: synchronous, active-high reset.
- iReq, input, NUM_REQ: per-requester request level.
- iAddr, input, NUM_REQ*ADDR_WIDTH: packed request addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- oGrant, output, NUM_REQ: combinational one-hot accept; the request is taken at the end of this cycle.
- oRomAddress, output, ADDR_WIDTH: registered address to the ROM.
- iRomData, input, DATA_WIDTH: ROM read data.
- oValid, output, NUM_REQ: registered one-hot return strobe.
- oData, output, DATA_WIDTH: registered return word, meaningful only while oValid is nonzero.

## Operation
- Handshake:
  - A transfer occurs in any cycle where iReq[i] and oGrant[i] are both high.
  - iAddr slice i must be stable while iReq[i] is high and no grant has occurred.
  - The requester may change iAddr or drop iReq[i] only after a granted edge.
  - Holding iReq[i] high after a grant issues a new access with the current iAddr.
- Arbitration:
  - rr_ptr holds the index of the last granted requester.
  - Each cycle, the search starts at (rr_ptr+1) mod NUM_REQ and wraps; the first requester with iReq set is granted.
  - rr_ptr updates to the granted index on each transfer and holds when there is no request.
  - At most one grant per cycle; oGrant is 0 when iReq is 0.
- Address path: on a transfer, oRomAddress is loaded with the granted address; otherwise it holds its value.
- Return path:
  - A tag pipeline of depth ROM_LATENCY+1 carries the one-hot grant alongside the access.
  - When the tag exits, oValid is set to the tag and oData is loaded from iRomData in the same edge.
  - Empty slots carry tag 0, so oValid is 0 for those cycles.
- Fairness: with k requesters continuously requesting, each is granted exactly once every k cycles.

## Timing
- Reset values:
  - oRomAddress = 0, oValid = 0, oData = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 wins the first contended cycle.
  - All tag pipeline stages are cleared to 0.
- Latency: for a transfer in cycle N:
  - oRomAddress carries the address in cycle N+1.
  - iRomData carries the word in cycle N+1+ROM_LATENCY.
  - oValid/oData are valid in cycle N+2+ROM_LATENCY, which is N+4 with the default latency.
- Throughput: one transfer per cycle sustained, including one requester asserting iReq continuously.
- Reset mid-operation:
  - In-flight tags are discarded; no oValid pulse ever appears for a pre-reset transfer.
  - oGrant is forced to 0 during any cycle with iReset high.
- Simultaneous events: a new transfer and a return to the same requester in the same cycle are both honoured; they are independent pipeline stages.
- Wrap-around: the search index wraps modulo NUM_REQ, so requester NUM_REQ-1 is followed by requester 0.

## Configuration
- ARB_PRIORITY0_EN:
  - Defined: requester 0 (display scanout) has strict priority. Whenever iReq[0] is high it is granted, and rr_ptr is not updated by that grant. The remaining requesters rotate round-robin among themselves in cycles where iReq[0] is low.
  - Undefined: pure round-robin across all NUM_REQ requesters, as described above.

## Test plan
- Reset, then iReq=4'b0001 with addr0=0x00123 held for 1 cycle:
  - oGrant=0001 in that cycle.
  - oRomAddress=0x00123 the next cycle.
  - ROM model returns 0xBEEF; oValid=0001 with oData=0xBEEF exactly 4 cycles after the grant.
- iReq=4'b1111 held for 8 cycles after reset:
  - Grants in order 0,1,2,3,0,1,2,3.
  - oValid follows the same order, 4 cycles later, with the matching data.
- Only requester 2 requests, for 6 back-to-back cycles with addresses 10..15:
  - oGrant=0100 every cycle.
  - 6 consecutive oValid=0100 pulses returning ROM[10..15] in order.
- Requesters 1 and 3 request; requester 1 drops after its first grant:
  - Grants 1,3,3,3.
  - No grant to 0 or 2.
- iReset asserted for 1 cycle while 3 reads are in flight:
  - No oValid pulse for those 3 reads.
  - The next request from requesters 0 and 1 together grants requester 0 first.
- With ARB_PRIORITY0_EN, iReq=4'b0111 held for 3 cycles, then 4'b0110 for 2 cycles:
  - Grants 0,0,0, then 1,2.
